// File: rtl/sha1_core_if.sv
// Handshake/data bundle between the Wishbone SHA-1 register block (master)
// and the sha1_core compression engine (slave).
interface sha1_core_if;
    logic         on;
    logic         chain;
    logic [511:0] message;
    logic [159:0] digest;
    logic         done;
    logic         busy;
    logic [6:0]   loop_idx;
    logic         panic;

    modport master (
        output on, chain, message,
        input  digest, done, busy, loop_idx, panic
    );

    modport slave (
        input  on, chain, message,
        output digest, done, busy, loop_idx, panic
    );
endinterface

// File: rtl/sha1_core.sv
// Iterative SHA-1 compression engine, one round per clock (81 cycles per block).
// Optional SHA1_CORE_MULTIBLOCK_EN: chain=1 at start reuses the current digest as H_init.
module sha1_core (
    input  logic          wb_clk_i,
    input  logic          reset,
    input  logic          soft_reset,
    sha1_core_if.slave    bus
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ROUND = 2'd1;
    localparam logic [1:0] ST_FINAL = 2'd2;

    localparam logic [159:0] H_CONST = 160'h67452301_efcdab89_98badcfe_10325476_c3d2e1f0;

    logic [1:0]   state_r;
    logic         on_q_r;
    logic [6:0]   t_r;
    logic [31:0]  a_r, b_r, c_r, d_r, e_r;
    logic [31:0]  w_r [0:15];
    logic [159:0] digest_r;
    logic         done_r;
    logic         busy_r;
    logic         panic_r;

    logic         start_s;
    logic [31:0]  f_s;
    logic [31:0]  k_s;
    logic [31:0]  temp_s;
    logic [31:0]  w_new_s;
    logic [159:0] h_init_s;
    logic [159:0] h_load_s;

    function automatic logic [31:0] rotl(input logic [31:0] x, input int unsigned n);
        rotl = (x << n) | (x >> (32 - n));
    endfunction

`ifdef SHA1_CORE_MULTIBLOCK_EN
    logic [159:0] h_init_r;

    // Chaining source is the digest still held from the previous block.
    always_comb begin
        h_init_s = h_init_r;
        if (bus.chain) begin
            h_load_s = digest_r;
        end else begin
            h_load_s = H_CONST;
        end
    end

    // Hold the block's initial H for the final feed-forward addition.
    always_ff @(posedge wb_clk_i) begin
        if (reset || soft_reset) begin
            h_init_r <= 160'd0;
        end else if (state_r == ST_IDLE && start_s) begin
            h_init_r <= h_load_s;
        end else begin
            h_init_r <= h_init_r;
        end
    end
`else
    logic chain_unused_s;
    assign chain_unused_s = bus.chain;
    assign h_init_s       = H_CONST;
    assign h_load_s       = H_CONST;
`endif

    // Round function, constant and message-schedule expansion for round t_r.
    always_comb begin
        start_s = bus.on & ~on_q_r;
        if (t_r < 7'd20) begin
            f_s = (b_r & c_r) | (~b_r & d_r);
            k_s = 32'h5a827999;
        end else if (t_r < 7'd40) begin
            f_s = b_r ^ c_r ^ d_r;
            k_s = 32'h6ed9eba1;
        end else if (t_r < 7'd60) begin
            f_s = (b_r & c_r) | (b_r & d_r) | (c_r & d_r);
            k_s = 32'h8f1bbcdc;
        end else begin
            f_s = b_r ^ c_r ^ d_r;
            k_s = 32'hca62c1d6;
        end
        temp_s  = rotl(a_r, 5) + f_s + e_r + k_s + w_r[0];
        // Window head is W[t]; this produces W[t+16] for the tail.
        w_new_s = rotl(w_r[13] ^ w_r[8] ^ w_r[2] ^ w_r[0], 1);
    end

    // Control FSM, working variables and status registers.
    always_ff @(posedge wb_clk_i) begin
        if (reset || soft_reset) begin
            state_r  <= ST_IDLE;
            on_q_r   <= bus.on;
            t_r      <= 7'd0;
            a_r      <= 32'd0;
            b_r      <= 32'd0;
            c_r      <= 32'd0;
            d_r      <= 32'd0;
            e_r      <= 32'd0;
            digest_r <= 160'd0;
            done_r   <= 1'b0;
            busy_r   <= 1'b0;
            panic_r  <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                w_r[i] <= 32'd0;
            end
        end else begin
            on_q_r <= bus.on;
            if (start_s && state_r != ST_IDLE) begin
                panic_r <= 1'b1;
            end else begin
                panic_r <= panic_r;
            end
            case (state_r)
                ST_IDLE: begin
                    if (start_s) begin
                        for (int i = 0; i < 16; i++) begin
                            w_r[i] <= bus.message[32*i +: 32];
                        end
                        a_r     <= h_load_s[159:128];
                        b_r     <= h_load_s[127:96];
                        c_r     <= h_load_s[95:64];
                        d_r     <= h_load_s[63:32];
                        e_r     <= h_load_s[31:0];
                        t_r     <= 7'd0;
                        done_r  <= 1'b0;
                        busy_r  <= 1'b1;
                        state_r <= ST_ROUND;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ROUND: begin
                    for (int i = 0; i < 15; i++) begin
                        w_r[i] <= w_r[i+1];
                    end
                    w_r[15] <= w_new_s;
                    e_r     <= d_r;
                    d_r     <= c_r;
                    c_r     <= rotl(b_r, 30);
                    b_r     <= a_r;
                    a_r     <= temp_s;
                    if (t_r == 7'd79) begin
                        state_r <= ST_FINAL;
                    end else begin
                        t_r <= t_r + 7'd1;
                    end
                end
                ST_FINAL: begin
                    digest_r <= {h_init_s[159:128] + a_r, h_init_s[127:96] + b_r,
                                 h_init_s[95:64] + c_r,   h_init_s[63:32] + d_r,
                                 h_init_s[31:0] + e_r};
                    done_r   <= 1'b1;
                    busy_r   <= 1'b0;
                    state_r  <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.digest   = digest_r;
    assign bus.done     = done_r;
    assign bus.busy     = busy_r;
    assign bus.loop_idx = t_r;
    assign bus.panic    = panic_r;

endmodule

// File: tb/tb_sha1_core.sv
// Self-checking bench for sha1_core: known vectors, random blocks against a
// textbook SHA-1 model, and reset/panic/latched-message boundary cases.
module tb_sha1_core;

    localparam logic [159:0] H_CONST   = 160'h67452301_efcdab89_98badcfe_10325476_c3d2e1f0;
    localparam logic [159:0] ABC_DIG   = 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d;
    localparam logic [159:0] EMPTY_DIG = 160'hda39a3ee_5e6b4b0d_3255bfef_95601890_afd80709;
    localparam logic [159:0] MB_DIG    = 160'h84983e44_1c3bd26e_baae4aa1_f95129e5_e54670f1;

    logic clk;
    logic reset;
    logic soft_reset;
    int   checks;
    int   failures;

    sha1_core_if bus ();

    sha1_core dut (
        .wb_clk_i   (clk),
        .reset      (reset),
        .soft_reset (soft_reset),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rl(input logic [31:0] x, input int n);
        rl = (x << n) | (x >> (32 - n));
    endfunction

    // Straight FIPS 180-4 compression of one block with a full 80-word schedule.
    function automatic logic [159:0] sha1_ref(input logic [511:0] m, input logic [159:0] hin);
        logic [31:0] w [80];
        logic [31:0] a, b, c, d, e, f, k, tmp;
        for (int t = 0; t < 16; t++) w[t] = m[32*t +: 32];
        for (int t = 16; t < 80; t++) w[t] = rl(w[t-3] ^ w[t-8] ^ w[t-14] ^ w[t-16], 1);
        a = hin[159:128]; b = hin[127:96]; c = hin[95:64]; d = hin[63:32]; e = hin[31:0];
        for (int t = 0; t < 80; t++) begin
            if (t < 20)      begin f = (b & c) | (~b & d);          k = 32'h5a827999; end
            else if (t < 40) begin f = b ^ c ^ d;                   k = 32'h6ed9eba1; end
            else if (t < 60) begin f = (b & c) | (b & d) | (c & d); k = 32'h8f1bbcdc; end
            else             begin f = b ^ c ^ d;                   k = 32'hca62c1d6; end
            tmp = rl(a, 5) + f + e + k + w[t];
            e = d; d = c; c = rl(b, 30); b = a; a = tmp;
        end
        sha1_ref = {hin[159:128] + a, hin[127:96] + b, hin[95:64] + c, hin[63:32] + d, hin[31:0] + e};
    endfunction

    task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // mode 0: plain; 1: drop/re-raise on around round 10; 2: message to all-ones after start.
    task automatic do_block(input logic [511:0] msg, input logic ch, input int mode,
                            output logic [159:0] dig, output int lat);
        @(negedge clk);
        bus.message = msg;
        bus.chain   = ch;
        bus.on      = 1'b1;
        lat = -1;
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk);
            if (n == 1) begin
                check("busy_after_start", {159'd0, bus.busy}, 160'd1);
                check("idx_after_start", {153'd0, bus.loop_idx}, 160'd0);
                if (mode == 2) bus.message = '1;
            end
            if (mode == 1 && n == 11) bus.on = 1'b0;
            if (mode == 1 && n == 12) bus.on = 1'b1;
            if (bus.done) begin
                lat = n - 1;
                break;
            end
        end
        dig    = bus.digest;
        bus.on = 1'b0;
    endtask

    initial begin
        logic [511:0] msg;
        logic [511:0] abc_msg;
        logic [159:0] dig;
        logic [159:0] exp;
        int           lat;
        int           waited;
        logic [31:0]  b1w [14];

        checks = 0;
        failures = 0;
        bus.on = 1'b1;
        bus.chain = 1'b0;
        bus.message = '0;
        soft_reset = 1'b0;
        reset = 1'b1;
        abc_msg = '0;
        abc_msg[31:0]    = 32'h61626380;
        abc_msg[511:480] = 32'h00000018;

        // Reset state, with on held high through reset
        repeat (3) @(negedge clk);
        check("rst_digest", bus.digest, 160'd0);
        check("rst_done", {159'd0, bus.done}, 160'd0);
        check("rst_busy", {159'd0, bus.busy}, 160'd0);
        check("rst_idx", {153'd0, bus.loop_idx}, 160'd0);
        check("rst_panic", {159'd0, bus.panic}, 160'd0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("on_held_no_start", {159'd0, bus.busy}, 160'd0);
        bus.on = 1'b0;

        // "abc"
        do_block(abc_msg, 1'b0, 0, dig, lat);
        check("abc_digest", dig, ABC_DIG);
        check("abc_latency", lat, 160'd81);
        check("abc_idx79", {153'd0, bus.loop_idx}, 160'd79);
        check("abc_busy_low", {159'd0, bus.busy}, 160'd0);
        repeat (2) @(negedge clk);
        check("done_holds", {159'd0, bus.done}, 160'd1);
        check("idx_holds", {153'd0, bus.loop_idx}, 160'd79);

        // Empty string
        msg = '0;
        msg[31:0] = 32'h80000000;
        do_block(msg, 1'b0, 0, dig, lat);
        check("empty_digest", dig, EMPTY_DIG);

        // Random blocks against the model
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 16; i++) msg[32*i +: 32] = $urandom();
            do_block(msg, 1'b0, 0, dig, lat);
            check("rand_digest", dig, sha1_ref(msg, H_CONST));
            check("rand_latency", lat, 160'd81);
        end

        // Message bus changed right after start
        do_block(abc_msg, 1'b0, 2, dig, lat);
        check("latched_msg", dig, ABC_DIG);

        // Restart while busy raises sticky panic, block still completes
        do_block(abc_msg, 1'b0, 1, dig, lat);
        check("panic_digest", dig, ABC_DIG);
        check("panic_latency", lat, 160'd81);
        check("panic_set", {159'd0, bus.panic}, 160'd1);
        do_block(abc_msg, 1'b0, 0, dig, lat);
        check("panic_sticky", {159'd0, bus.panic}, 160'd1);
        check("after_panic_digest", dig, ABC_DIG);

        // Soft reset mid-block at round 40
        @(negedge clk);
        bus.message = abc_msg;
        bus.on = 1'b1;
        waited = 0;
        while (bus.loop_idx != 7'd40 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        check("reach_round40", {153'd0, bus.loop_idx}, 160'd40);
        soft_reset = 1'b1;
        @(negedge clk);
        soft_reset = 1'b0;
        check("srst_busy", {159'd0, bus.busy}, 160'd0);
        check("srst_done", {159'd0, bus.done}, 160'd0);
        check("srst_digest", bus.digest, 160'd0);
        check("srst_idx", {153'd0, bus.loop_idx}, 160'd0);
        check("srst_panic", {159'd0, bus.panic}, 160'd0);
        repeat (3) @(negedge clk);
        check("srst_no_restart", {159'd0, bus.busy}, 160'd0);
        bus.on = 1'b0;
        do_block(abc_msg, 1'b0, 0, dig, lat);
        check("srst_abc_digest", dig, ABC_DIG);

        // Two-block message
        b1w = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768,
                32'h66676869, 32'h6768696a, 32'h68696a6b, 32'h696a6b6c, 32'h6a6b6c6d,
                32'h6b6c6d6e, 32'h6c6d6e6f, 32'h6d6e6f70, 32'h6e6f7071};
        msg = '0;
        for (int i = 0; i < 14; i++) msg[32*i +: 32] = b1w[i];
        msg[479:448] = 32'h80000000;
        do_block(msg, 1'b0, 0, dig, lat);
        check("mb_block1", dig, sha1_ref(msg, H_CONST));
        msg = '0;
        msg[511:480] = 32'h000001c0;
`ifdef SHA1_CORE_MULTIBLOCK_EN
        exp = MB_DIG;
`else
        exp = sha1_ref(msg, H_CONST);
`endif
        do_block(msg, 1'b1, 0, dig, lat);
        check("mb_block2", dig, exp);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
